sram_rr_arbiter: RTL

//  Two-master arbiter that shares the single-port on-chip SRAM (picosoc_mem-style, 1-cycle read latency)

---
 rtl/sram_rr_arbiter_if.sv | 44 ++++
 rtl/sram_rr_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter_if.sv
// Bus bundle between the two picorv32-native requesters, the arbiter and the
// single-port SRAM macro. The arbiter takes the slave side; the requesters
// and the SRAM model take the master side.
interface sram_rr_arbiter_if #(
  parameter int AW = 16
);
  // requester 0 (CPU native port)
  logic          m0_valid;
  logic [31:0]   m0_addr;
  logic [31:0]   m0_wdata;
  logic [3:0]    m0_wstrb;
  logic          m0_ready;
  logic [31:0]   m0_rdata;
  // requester 1 (DMA or other second master)
  logic          m1_valid;
  logic [31:0]   m1_addr;
  logic [31:0]   m1_wdata;
  logic [3:0]    m1_wstrb;
  logic          m1_ready;
  logic [31:0]   m1_rdata;
  // SRAM macro side
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output ram_wen, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  ram_wen, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-master arbiter in front of a single-port SRAM with 1-cycle registered
// read. One transaction at a time: IDLE (arbitrate) -> ACC (drive SRAM) ->
// RSP (return ready/rdata), so a grant costs exactly 3 cycles. On contention
// the masters alternate (ROUND_ROBIN=1) or m0 always wins (ROUND_ROBIN=0).
module sram_rr_arbiter #(
  parameter int WORDS       = 65536,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  sram_rr_arbiter_if.slave   bus
);

  localparam int AW = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_gnt;        // granted master index
  logic        w_gnt_next;
  logic        r_last;       // master served most recently; reset to 1 so m0 wins the first tie
  logic        w_last_next;

  logic [1:0]  w_valid;
  logic [1:0]  w_ready;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_wstrb;
  logic        w_unused_addr;

  assign w_valid = {bus.m1_valid, bus.m0_valid};

  // Address/data are taken live from the granted master during ACC; they are
  // not captured at grant time, so a master that misbehaves still gets a
  // well-defined (if meaningless) access.
  assign w_sel_addr  = r_gnt ? bus.m1_addr  : bus.m0_addr;
  assign w_sel_wdata = r_gnt ? bus.m1_wdata : bus.m0_wdata;
  assign w_sel_wstrb = r_gnt ? bus.m1_wstrb : bus.m0_wstrb;

  // Byte-offset and above-depth address bits are intentionally ignored; the
  // decoder guarantees the address is in range.
  assign w_unused_addr = ^w_sel_addr;

  // Per-master response: ready pulses in RSP for the granted master only;
  // rdata is forced to zero for everybody else so a waiting master sees 0.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign w_ready[gi] = (r_state == ST_RSP) && (r_gnt == 1'(gi));
    end
  endgenerate

  assign bus.m0_ready = w_ready[0];
  assign bus.m1_ready = w_ready[1];
  assign bus.m0_rdata = w_ready[0] ? bus.ram_rdata : 32'h0;
  assign bus.m1_rdata = w_ready[1] ? bus.ram_rdata : 32'h0;

  // State, grant and round-robin history registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_last  <= w_last_next;
    end
  end

  // Next-state, arbitration decision and SRAM drive for the current state
  always_comb begin
    w_state_next  = r_state;
    w_gnt_next    = r_gnt;
    w_last_next   = r_last;
    bus.ram_wen   = 4'h0;
    bus.ram_addr  = '0;
    bus.ram_wdata = 32'h0;

    case (r_state)
      ST_IDLE: begin
        if (|w_valid) begin
          w_state_next = ST_ACC;
          if (&w_valid) begin
            // Tie: alternate away from the last winner, or favour m0.
            w_gnt_next = ROUND_ROBIN ? ~r_last : 1'b0;
          end else begin
            w_gnt_next = w_valid[1];
          end
        end
      end

      ST_ACC: begin
        // Single SRAM access cycle; write enables exist only here.
        bus.ram_addr  = w_sel_addr[AW+1:2];
        bus.ram_wdata = w_sel_wdata;
        bus.ram_wen   = w_sel_wstrb;
        w_last_next   = r_gnt;
        w_state_next  = ST_RSP;
      end

      ST_RSP: begin
        // Registered SRAM read data is valid now; ready is driven above.
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
